// File: rtl/class_hvec_store_if.sv
// Command, write-frame and read-frame channels of the class hypervector store.
// slave = store side, master = loader / similarity-stage side.
interface class_hvec_store_if #(
    parameter int NUM_CLASSES = 8,
    parameter int FRAME_W     = 64,
    parameter int NUM_FRAMES  = 3
);
    localparam int CLS_W = $clog2(NUM_CLASSES);
    localparam int IDX_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;

    logic                   cmd_valid;
    logic                   cmd_ready;
    logic                   cmd_wr;
    logic [CLS_W-1:0]       cmd_class;
    logic                   clr;
    logic                   in_valid;
    logic                   in_ready;
    logic [FRAME_W-1:0]     in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [FRAME_W-1:0]     out_data;
    logic [CLS_W-1:0]       out_class;
    logic [IDX_W-1:0]       out_index;
    logic                   out_last;
    logic                   err;
    logic [NUM_CLASSES-1:0] loaded;

    modport slave (
        input  cmd_valid, cmd_wr, cmd_class, clr, in_valid, in_data, out_ready,
        output cmd_ready, in_ready, out_valid, out_data, out_class, out_index,
               out_last, err, loaded
    );

    modport master (
        output cmd_valid, cmd_wr, cmd_class, clr, in_valid, in_data, out_ready,
        input  cmd_ready, in_ready, out_valid, out_data, out_class, out_index,
               out_last, err, loaded
    );
endinterface

// File: rtl/class_hvec_store.sv
// Run-time loadable class hypervector store: one command loads or streams a whole class vector.
// Read: frame 0 one cycle after command acceptance, then one frame/cycle; outputs hold while out_ready=0.
module class_hvec_store #(
    parameter int NUM_CLASSES = 8,
    parameter int FRAME_W     = 64,
    parameter int NUM_FRAMES  = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    class_hvec_store_if.slave  bus
);
    localparam int CLS_W = $clog2(NUM_CLASSES);
    localparam int IDX_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
    localparam int DEPTH = NUM_CLASSES * NUM_FRAMES;
    localparam int AW    = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FRAMES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WR, S_RD} state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [FRAME_W-1:0]     r_mem [DEPTH];
    logic [CLS_W-1:0]       r_cls;
    logic [IDX_W-1:0]       r_cnt;
    logic [NUM_CLASSES-1:0] r_loaded;
    logic                   r_err;
    logic                   r_out_vld;
    logic                   r_out_last;
    logic [FRAME_W-1:0]     r_out_dat;
    logic [IDX_W-1:0]       r_out_idx;
    logic [CLS_W-1:0]       r_out_cls;

    logic                   w_cmd_fire;
    logic                   w_cmd_legal;
    logic                   w_wr_fire;
    logic                   w_wr_last;
    logic                   w_rd_fire;
    logic                   w_rd_load;
    logic [IDX_W-1:0]       w_rd_idx;
    logic [AW-1:0]          w_rd_addr;
    logic [AW-1:0]          w_wr_addr;

    assign w_cmd_fire  = bus.cmd_valid && (r_state == S_IDLE);
    assign w_cmd_legal = {1'b0, bus.cmd_class} < (CLS_W+1)'(NUM_CLASSES);
    assign w_wr_fire   = (r_state == S_WR) && bus.in_valid;
    assign w_wr_last   = w_wr_fire && (r_cnt == LAST_IDX);
    assign w_rd_fire   = r_out_vld && bus.out_ready;

    // The output register is primed once on RD entry, then refilled on every non-final fire.
    assign w_rd_load   = (r_state == S_RD) && (!r_out_vld || (w_rd_fire && !r_out_last));
    assign w_rd_idx    = r_out_vld ? r_out_idx + 1'b1 : '0;
    assign w_rd_addr   = AW'(r_cls) * AW'(NUM_FRAMES) + AW'(w_rd_idx);
    assign w_wr_addr   = AW'(r_cls) * AW'(NUM_FRAMES) + AW'(r_cnt);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_cmd_fire && w_cmd_legal) w_next = bus.cmd_wr ? S_WR : S_RD;
            S_WR:   if (w_wr_last) w_next = S_IDLE;
            S_RD:   if (w_rd_fire && r_out_last) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cls      <= '0;
            r_cnt      <= '0;
            r_loaded   <= '0;
            r_err      <= 1'b0;
            r_out_vld  <= 1'b0;
            r_out_last <= 1'b0;
            r_out_dat  <= '0;
            r_out_idx  <= '0;
            r_out_cls  <= '0;
        end else begin
            r_state <= w_next;
            r_err   <= w_cmd_fire && !w_cmd_legal;

            if (w_cmd_fire && w_cmd_legal) begin
                r_cls <= bus.cmd_class;
                r_cnt <= '0;
            end else if (w_wr_fire) begin
                r_cnt <= w_wr_last ? '0 : r_cnt + 1'b1;
            end

            // clr beats a simultaneous final write
            if (bus.clr)        r_loaded <= '0;
            else if (w_wr_last) r_loaded[r_cls] <= 1'b1;

            if (w_rd_load) begin
                r_out_vld  <= 1'b1;
                r_out_dat  <= r_loaded[r_cls] ? r_mem[w_rd_addr] : '0;
                r_out_idx  <= w_rd_idx;
                r_out_cls  <= r_cls;
                r_out_last <= (w_rd_idx == LAST_IDX);
            end else if (w_rd_fire) begin
                r_out_vld  <= 1'b0;
                r_out_last <= 1'b0;
            end
        end
    end

    // Vector storage deliberately has no reset; the loaded flags gate stale contents.
    always_ff @(posedge clk) begin
        if (w_wr_fire) r_mem[w_wr_addr] <= bus.in_data;
    end

    assign bus.cmd_ready = (r_state == S_IDLE);
    assign bus.in_ready  = (r_state == S_WR);
    assign bus.out_valid = r_out_vld;
    assign bus.out_data  = r_out_dat;
    assign bus.out_class = r_out_cls;
    assign bus.out_index = r_out_idx;
    assign bus.out_last  = r_out_last;
    assign bus.err       = r_err;
    assign bus.loaded    = r_loaded;
endmodule
